// File: rtl/aes_req_sched_pkg.sv
// Shared types for the two-requester AES engine scheduler.
// Widths match the aes_top key/block sizes.
package aes_req_sched_pkg;

  localparam int KEY_S = 128;
  localparam int BLK_S = 128;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    LAUNCH,
    WAIT,
    FLUSH,
    RESP
  } state_e;

  typedef struct packed {
    logic [BLK_S-1:0] data;
    logic             err;
  } resp_t;

endpackage

// File: rtl/aes_req_sched_arb.sv
// Two-way round-robin grant for the shared AES engine.
// last_grant starts at 1 so requester 0 wins the first tie.
module aes_rr_arb (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic upd,
  input  logic upd_id,
  output logic gnt_valid,
  output logic gnt_id
);

  logic last_q;

  // remember who was served last, updated on response handshake
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= 1'b1;
    end else if (upd) begin
      last_q <= upd_id;
    end
  end

  // lone requester wins; a tie goes to whoever was not served last
  always_comb begin
    gnt_valid = req0 | req1;
    gnt_id    = 1'b0;
    unique case (1'b1)
      (req0 && req1):  gnt_id = ~last_q;
      (!req0 && req1): gnt_id = 1'b1;
      default:         gnt_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/aes_req_sched.sv
// Round-robin job scheduler in front of one aes_top engine.
// Launches jobs, waits with a watchdog, returns per-requester results.
module aes_req_sched
  import aes_req_sched_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int RST_CYC = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [KEY_S-1:0] req0_key,
  input  logic [BLK_S-1:0] req0_blk,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [KEY_S-1:0] req1_key,
  input  logic [BLK_S-1:0] req1_blk,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [BLK_S-1:0] resp0_data,
  output logic             resp0_err,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [BLK_S-1:0] resp1_data,
  output logic             resp1_err,
  output logic             aes_en,
  output logic [KEY_S-1:0] aes_key,
  output logic [BLK_S-1:0] aes_plaintext,
  input  logic [BLK_S-1:0] aes_ciphertext,
  input  logic             aes_en_o,
  output logic             aes_reset,
  output logic             busy,
  output logic             grant_id
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYC - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [KEY_S-1:0] key_q, key_d;
  logic [BLK_S-1:0] blk_q, blk_d;
  logic             gid_q, gid_d;
  resp_t            resp_q, resp_d;
  logic             gnt_valid, gnt_id;
  logic             accept, resp_hs;

  aes_rr_arb u_arb (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0_valid),
    .req1      (req1_valid),
    .upd       (resp_hs),
    .upd_id    (gid_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  assign cnt_inc = cnt_q + CW'(1);
  assign accept  = (state_q == IDLE) && gnt_valid;
  assign resp_hs = (state_q == RESP) &&
                   (gid_q ? resp1_ready : resp0_ready);

  // state and shared init/watchdog/flush counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // job registers: launch operands, owner and captured result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_q  <= '0;
      blk_q  <= '0;
      gid_q  <= 1'b0;
      resp_q <= '0;
    end else begin
      key_q  <= key_d;
      blk_q  <= blk_d;
      gid_q  <= gid_d;
      resp_q <= resp_d;
    end
  end

  // next state; the timeout fires on the edge where the counter
  // reaches TIMEOUT-1, so FLUSH starts TIMEOUT cycles after aes_en
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    blk_d   = blk_q;
    gid_d   = gid_q;
    resp_d  = resp_q;
    unique case (state_q)
      INIT: begin
        if (cnt_q == RST_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      IDLE: begin
        if (accept) begin
          key_d   = gnt_id ? req1_key : req0_key;
          blk_d   = gnt_id ? req1_blk : req0_blk;
          gid_d   = gnt_id;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_inc;
        if (aes_en_o) begin
          resp_d.data = aes_ciphertext;
          resp_d.err  = 1'b0;
          state_d     = RESP;
        end else if (cnt_inc == TO_LAST) begin
          resp_d.data = '0;
          resp_d.err  = 1'b1;
          cnt_d       = '0;
          state_d     = FLUSH;
        end
      end
      FLUSH: begin
        if (cnt_q == RST_LAST) begin
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RESP: begin
        if (resp_hs) begin
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = INIT;
      end
    endcase
  end

  // busy is gated by reset so it reads 0 while reset is held
  always_comb begin
    req0_ready    = accept && !gnt_id;
    req1_ready    = accept && gnt_id;
    aes_en        = (state_q == LAUNCH);
    aes_reset     = (state_q == INIT) || (state_q == FLUSH);
    aes_key       = key_q;
    aes_plaintext = blk_q;
    resp0_valid   = (state_q == RESP) && !gid_q;
    resp1_valid   = (state_q == RESP) && gid_q;
    resp0_data    = resp_q.data;
    resp1_data    = resp_q.data;
    resp0_err     = resp_q.err;
    resp1_err     = resp_q.err;
    busy          = reset && (state_q != IDLE);
    grant_id      = gid_q;
  end

endmodule

// File: doc/aes_req_sched.md
Name: aes_req_sched

Overview:
- Round-robin scheduler that shares one aes_top encryption engine between two requesters.
- Accepts key/plaintext jobs over valid/ready and launches each as a single en pulse to the engine.
- Waits for en_o and returns the ciphertext over a per-requester valid/ready response channel.
- Sits between the bus-side request logic and aes_top; runs a watchdog that resets and recovers a hung engine.

Parameters:
- KEY_S, `KEY_S (128): key width.
- BLK_S, `BLK_S (128): block width.
- TIMEOUT, 64: max cycles in WAIT before the job is declared failed.
- RST_CYC, 2: cycles aes_reset is held high on init/recovery.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  job offered
- req0_ready / req1_ready  out  1  job accepted when valid&ready
- req0_key / req1_key  in  KEY_S  job key
- req0_blk / req1_blk  in  BLK_S  job plaintext
- resp0_valid / resp1_valid  out  1  result available
- resp0_ready / resp1_ready  in  1  result consumed when valid&ready
- resp0_data / resp1_data  out  BLK_S  ciphertext; 0 on error
- resp0_err / resp1_err  out  1  job timed out
- aes_en  out  1  one-cycle launch pulse to engine
- aes_key  out  KEY_S  engine key
- aes_plaintext  out  BLK_S  engine plaintext
- aes_ciphertext  in  BLK_S  engine result
- aes_en_o  in  1  engine done pulse
- aes_reset  out  1  active-high engine reset
- busy  out  1  state != IDLE
- grant_id  out  1  requester owning the engine

Behaviour:
- Reset values (reset low):
  - state=INIT, aes_reset=1, all other outputs 0.
  - last_grant=1, so req0 wins the first tie.
- INIT: hold aes_reset=1 for RST_CYC cycles after reset release, then go to IDLE.
- IDLE arbitration:
  - If exactly one reqN_valid, grant N.
  - If both are valid, grant !last_grant.
  - reqN_ready=1 combinationally only for the granted N, and only in IDLE.
  - On the handshake, register key, blk and grant_id, then go to LAUNCH.
- LAUNCH:
  - aes_en=1 for exactly one cycle.
  - aes_key/aes_plaintext are driven from the registers and stay stable from LAUNCH until the next accept.
  - Clear the watchdog counter; go to WAIT.
- WAIT:
  - The counter increments each cycle.
  - On aes_en_o: capture aes_ciphertext, set err=0, go to RESP.
  - If the counter reaches TIMEOUT-1 without aes_en_o: set data=0, err=1, go to FLUSH.
  - If aes_en_o and the timeout occur in the same cycle, aes_en_o wins.
- FLUSH: aes_reset=1 for RST_CYC cycles, then go to RESP.
- RESP:
  - resp{grant_id}_valid=1; data and err stay stable until the handshake.
  - The other response valid stays 0.
  - On respN_ready: last_grant=grant_id, go to IDLE.
- Backpressure: while in RESP, no new job is accepted (both req_ready=0).
- aes_en_o outside WAIT is ignored; no state change.
- Latency from accept edge to result:
  - aes_en is high in cycle +1.
  - resp_valid rises the cycle after aes_en_o.
  - Overhead is 2 cycles plus engine latency.
- busy is high whenever state != IDLE.
- Reset mid-operation:
  - Asynchronously returns to the reset values; the in-flight job is dropped with no response.
  - The INIT reset pulse follows.
- Counter width: $clog2(TIMEOUT)+1; no wrap possible.

Decomposition:
- Shared package: state enum (INIT, IDLE, LAUNCH, WAIT, FLUSH, RESP) and the response record typedef {data, err}.
- KEY_S/BLK_S come from aes.vh.
- One natural sub-module: aes_rr_arb (2-way round-robin grant with last_grant register).
- aes_top is not instantiated inside; it is wired alongside at integration level.

Test Plan:
All scenarios use aes_top, or a bench model of it, with key 5468617473206D79204B756E67204675 and plaintext 54776F204F6E65204E696E652054776F.
1. Single req0 job -> one aes_en pulse; resp0_valid with data 29c3505f571420f6402299b31a02d73a, err=0; resp1_valid never high.
2. req0 and req1 valid on the same cycle after reset -> req0 served first, then req1. Both get 29c3505f…d73a, and grant_id sequence is 0, 1.
3. resp0_ready held low 10 cycles -> resp0_data/err stable throughout; req1_ready=0 throughout; req1 is accepted the cycle after the resp0 handshake.
4. Engine model never asserts en_o -> aes_reset high RST_CYC cycles starting TIMEOUT cycles after aes_en; resp0 err=1, data=0. The next job completes normally.
5. reset pulled low mid-WAIT -> all outputs at reset values immediately; no response issued; aes_reset high for RST_CYC cycles after release.
6. aes_en_o pulsed in IDLE with no job -> no state change; busy stays 0; no resp_valid.
